// File: rtl/sbus_pkg.sv
// Shared types and helpers for the SBUS core-memory responder.
package sbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACK_WAIT,
        ACCESS,
        RD_XFER,
        PAUSE,
        WR_XFER
    } tSBUSstate;

    typedef logic [0:3]   tWordMask;
    typedef logic [14:35] tSBUSadr;
    typedef logic [0:35]  tWord;

    // Odd parity bit for a value: makes the total number of ones odd.
    // Narrower fields (e.g. the address) are zero-extended by the caller.
    function automatic logic oddPar(input tWord w);
        return ~(^w);
    endfunction

endpackage

// File: rtl/sbus_core_mem_if.sv
// SBUS request/response bundle between the MBOX (master) and a memory (slave).
interface sbus_core_mem_if;
    import sbus_pkg::*;

    logic     START;
    logic     RD_RQ;
    logic     WR_RQ;
    tWordMask RQ;
    tSBUSadr  ADR;
    logic     ADR_PAR;
    tWord     DATA_IN;
    logic     DATA_PAR_IN;
    logic     ACKN;
    logic     DATA_VALID;
    tWord     DATA_OUT;
    logic     DATA_PAR_OUT;
    logic     ERROR;

    modport master (
        output START, RD_RQ, WR_RQ, RQ, ADR, ADR_PAR, DATA_IN, DATA_PAR_IN,
        input  ACKN, DATA_VALID, DATA_OUT, DATA_PAR_OUT, ERROR
    );

    modport slave (
        input  START, RD_RQ, WR_RQ, RQ, ADR, ADR_PAR, DATA_IN, DATA_PAR_IN,
        output ACKN, DATA_VALID, DATA_OUT, DATA_PAR_OUT, ERROR
    );

endinterface

// File: rtl/sbus_quad_seq.sv
// Walks the requested words of a quad: starting at the start word, it
// presents the next still-pending mask bit in mod-4 order. Each advance
// retires the current word; skipped (unrequested) words cost nothing.
module sbus_quad_seq
    import sbus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  tWordMask   mask,
    input  logic [1:0] start,
    input  logic       advance,
    output logic [1:0] word,
    output logic       last,
    output logic       empty
);

    tWordMask   rem_reg;
    logic [1:0] pos_reg;
    logic [0:3] rot;
    logic [1:0] off;

    // Pending mask rotated so that rot[0] is the start word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot[gi] = rem_reg[pos_reg + 2'(gi)];
        end
    endgenerate

    // First pending word at or after the start word.
    always_comb begin
        off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) begin
                off = 2'(k);
            end
        end
    end

    assign word  = pos_reg + off;
    assign last  = ($countones(rem_reg) == 1);
    assign empty = (rem_reg == '0);

    // Pending-word bookkeeping; the start position stays fixed for the pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg <= '0;
            pos_reg <= 2'd0;
        end else if (load) begin
            rem_reg <= mask;
            pos_reg <= start;
        end else if (advance) begin
            rem_reg[word] <= 1'b0;
        end
    end

endmodule

// File: rtl/sbus_core_mem.sv
// SBUS core-memory responder: accepts quad read / write / read-pause-write
// requests, holds data in an internal word array and strobes each word.
module sbus_core_mem
    import sbus_pkg::*;
#(
    parameter int BASE       = 0,
    parameter int SIZE_WORDS = 4096,
    parameter int ACKN_DLY   = 2,
    parameter int ACCESS_DLY = 4,
    parameter int WORD_DLY   = 0,
    parameter int PAUSE_DLY  = 2
)(
    input  logic            clk,
    input  logic            CROBAR,
    sbus_core_mem_if.slave  bus
);

    localparam int AW    = $clog2(SIZE_WORDS);
    localparam int MAX_A = (ACKN_DLY > ACCESS_DLY) ? ACKN_DLY : ACCESS_DLY;
    localparam int MAX_B = (WORD_DLY > PAUSE_DLY) ? WORD_DLY : PAUSE_DLY;
    localparam int MAXD  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAXD < 2) ? 1 : $clog2(MAXD + 1);

    // A PAUSE_DLY of 0 is treated as 1: the sequencer needs a cycle to rewind.
    localparam logic [CW-1:0] ACKN_LOAD   = CW'(ACKN_DLY - 1);
    localparam logic [CW-1:0] ACCESS_LOAD = CW'(ACCESS_DLY - 1);
    localparam logic [CW-1:0] WORD_LOAD   = CW'(WORD_DLY);
    localparam logic [CW-1:0] PAUSE_LOAD  = CW'((PAUSE_DLY > 0) ? PAUSE_DLY - 1 : 0);

    tWord mem [SIZE_WORDS];

    tSBUSstate  state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic       rd_reg, wr_reg, adr_par_reg;
    tWordMask   mask_reg;
    tSBUSadr    adr_reg;
    logic       ackn_reg, ackn_next;
    logic       err_reg, err_next;
    logic       dv_reg;
    tWord       data_out_reg;
    logic [1:0] strobe_word_reg;
    logic       last_fired_reg;

    logic       latch, fire, fire_rd, seq_load;
    logic [1:0] seq_word;
    logic       seq_last, seq_empty;
    tWordMask   seq_mask;
    logic [1:0] seq_start;
    logic       adr_par_ok, in_range, data_par_ok, wr_strobe;
    logic [31:0] adr_ext;

    // Array index of a word within the latched quad.
    function automatic logic [AW-1:0] mem_index(input tSBUSadr a, input logic [1:0] w);
        logic [21:0] wa;
        wa = {a[14:33], w} - 22'(BASE);
        return wa[AW-1:0];
    endfunction

    assign adr_ext     = {10'b0, adr_reg};
    assign adr_par_ok  = (oddPar(36'(adr_reg)) == adr_par_reg);
    assign in_range    = (adr_ext >= 32'(BASE)) && (adr_ext < 32'(BASE + SIZE_WORDS));
    assign data_par_ok = (oddPar(bus.DATA_IN) == bus.DATA_PAR_IN);
    assign wr_strobe   = dv_reg && (state_reg == WR_XFER);

    // In IDLE the sequencer loads straight from the bus; PAUSE reuses the latch.
    assign seq_mask  = (state_reg == IDLE) ? bus.RQ : mask_reg;
    assign seq_start = (state_reg == IDLE) ? bus.ADR[34:35] : adr_reg[34:35];

    sbus_quad_seq u_seq (
        .clk     (clk),
        .rst     (CROBAR),
        .load    (seq_load),
        .mask    (seq_mask),
        .start   (seq_start),
        .advance (fire),
        .word    (seq_word),
        .last    (seq_last),
        .empty   (seq_empty)
    );

    // Next-state, delay counter and strobe decisions.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ackn_next  = 1'b0;
        err_next   = 1'b0;
        fire       = 1'b0;
        seq_load   = 1'b0;
        latch      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.START) begin
                    latch    = 1'b1;
                    seq_load = 1'b1;
                    if (bus.RD_RQ || bus.WR_RQ) begin
                        state_next = ACK_WAIT;
                        cnt_next   = ACKN_LOAD;
                    end
                end
            end
            ACK_WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (!adr_par_ok) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (!in_range) begin
                    state_next = IDLE;
                end else begin
                    ackn_next  = 1'b1;
                    state_next = ACCESS;
                    cnt_next   = ACCESS_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (seq_empty) begin
                    state_next = IDLE;
                end else begin
                    fire       = 1'b1;
                    state_next = rd_reg ? RD_XFER : WR_XFER;
                end
            end
            RD_XFER, WR_XFER: begin
                if (last_fired_reg) begin
                    if (state_reg == RD_XFER && wr_reg) begin
                        state_next = PAUSE;
                        cnt_next   = PAUSE_LOAD;
                        seq_load   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    fire = 1'b1;
                end
            end
            PAUSE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    fire       = 1'b1;
                    state_next = WR_XFER;
                end
            end
            default: state_next = IDLE;
        endcase
        if (fire) begin
            cnt_next = WORD_LOAD;
        end
    end

    assign fire_rd = fire && (state_next == RD_XFER);

    // State and delay counter.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Request latch, captured when START is seen in IDLE.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            rd_reg      <= 1'b0;
            wr_reg      <= 1'b0;
            mask_reg    <= '0;
            adr_reg     <= '0;
            adr_par_reg <= 1'b0;
        end else if (latch) begin
            rd_reg      <= bus.RD_RQ;
            wr_reg      <= bus.WR_RQ;
            mask_reg    <= bus.RQ;
            adr_reg     <= bus.ADR;
            adr_par_reg <= bus.ADR_PAR;
        end
    end

    // Registered responses; read data is zero except in a read strobe cycle.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            ackn_reg        <= 1'b0;
            err_reg         <= 1'b0;
            dv_reg          <= 1'b0;
            data_out_reg    <= '0;
            strobe_word_reg <= 2'd0;
            last_fired_reg  <= 1'b0;
        end else begin
            ackn_reg     <= ackn_next;
            err_reg      <= err_next;
            dv_reg       <= fire;
            data_out_reg <= fire_rd ? mem[mem_index(adr_reg, seq_word)] : '0;
            if (fire) begin
                strobe_word_reg <= seq_word;
                last_fired_reg  <= seq_last;
            end
        end
    end

    // Write port: the word is taken at the edge that closes its strobe cycle,
    // while the MBOX is still holding it.
    always_ff @(posedge clk) begin
        if (wr_strobe) begin
            mem[mem_index(adr_reg, strobe_word_reg)] <= bus.DATA_IN;
        end
    end

    assign bus.ACKN         = ackn_reg;
    assign bus.DATA_VALID   = dv_reg;
    assign bus.DATA_OUT     = data_out_reg;
    assign bus.DATA_PAR_OUT = dv_reg & oddPar(data_out_reg);
    assign bus.ERROR        = err_reg | (wr_strobe & ~data_par_ok);

endmodule
